instr_decode_stage: RTL



---
 rtl/cpu31_pkg.sv | 83 ++++++++
 rtl/instr_onehot_decode.sv | 62 ++++++
 rtl/instr_decode_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu31_pkg.sv
// rtl/cpu31_pkg.sv - shared opcode/funct codes, one-hot indices and buffer state type
package cpu31_pkg;

  localparam int DEC_W = 32;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Bit positions in the decoded one-hot vector, shared with the controller
  localparam int IDX_ADD     = 0;
  localparam int IDX_ADDU    = 1;
  localparam int IDX_SUB     = 2;
  localparam int IDX_SUBU    = 3;
  localparam int IDX_AND     = 4;
  localparam int IDX_OR      = 5;
  localparam int IDX_XOR     = 6;
  localparam int IDX_NOR     = 7;
  localparam int IDX_SLT     = 8;
  localparam int IDX_SLTU    = 9;
  localparam int IDX_SLL     = 10;
  localparam int IDX_SRL     = 11;
  localparam int IDX_SRA     = 12;
  localparam int IDX_SLLV    = 13;
  localparam int IDX_SRLV    = 14;
  localparam int IDX_SRAV    = 15;
  localparam int IDX_JR      = 16;
  localparam int IDX_ADDI    = 17;
  localparam int IDX_ADDIU   = 18;
  localparam int IDX_ANDI    = 19;
  localparam int IDX_ORI     = 20;
  localparam int IDX_XORI    = 21;
  localparam int IDX_LUI     = 22;
  localparam int IDX_LW      = 23;
  localparam int IDX_SW      = 24;
  localparam int IDX_BEQ     = 25;
  localparam int IDX_BNE     = 26;
  localparam int IDX_SLTI    = 27;
  localparam int IDX_SLTIU   = 28;
  localparam int IDX_J       = 29;
  localparam int IDX_JAL     = 30;
  localparam int IDX_ILLEGAL = 31;

  // Occupancy of the output register plus skid slot
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/instr_onehot_decode.sv
// rtl/instr_onehot_decode.sv - combinational MIPS word to one-hot instruction vector
module instr_onehot_decode
  import cpu31_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [DEC_W-1:0] onehot
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register, shift-amount and immediate fields never affect the decode
  assign unused_fields = ^instr[25:6];

  // Map opcode/funct to exactly one set bit; unknown encodings flag illegal
  always_comb begin
    onehot = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  onehot[IDX_ADD]     = 1'b1;
          FN_ADDU: onehot[IDX_ADDU]    = 1'b1;
          FN_SUB:  onehot[IDX_SUB]     = 1'b1;
          FN_SUBU: onehot[IDX_SUBU]    = 1'b1;
          FN_AND:  onehot[IDX_AND]     = 1'b1;
          FN_OR:   onehot[IDX_OR]      = 1'b1;
          FN_XOR:  onehot[IDX_XOR]     = 1'b1;
          FN_NOR:  onehot[IDX_NOR]     = 1'b1;
          FN_SLT:  onehot[IDX_SLT]     = 1'b1;
          FN_SLTU: onehot[IDX_SLTU]    = 1'b1;
          FN_SLL:  onehot[IDX_SLL]     = 1'b1;
          FN_SRL:  onehot[IDX_SRL]     = 1'b1;
          FN_SRA:  onehot[IDX_SRA]     = 1'b1;
          FN_SLLV: onehot[IDX_SLLV]    = 1'b1;
          FN_SRLV: onehot[IDX_SRLV]    = 1'b1;
          FN_SRAV: onehot[IDX_SRAV]    = 1'b1;
          FN_JR:   onehot[IDX_JR]      = 1'b1;
          default: onehot[IDX_ILLEGAL] = 1'b1;
        endcase
      end
      OP_ADDI:  onehot[IDX_ADDI]    = 1'b1;
      OP_ADDIU: onehot[IDX_ADDIU]   = 1'b1;
      OP_ANDI:  onehot[IDX_ANDI]    = 1'b1;
      OP_ORI:   onehot[IDX_ORI]     = 1'b1;
      OP_XORI:  onehot[IDX_XORI]    = 1'b1;
      OP_LUI:   onehot[IDX_LUI]     = 1'b1;
      OP_LW:    onehot[IDX_LW]      = 1'b1;
      OP_SW:    onehot[IDX_SW]      = 1'b1;
      OP_BEQ:   onehot[IDX_BEQ]     = 1'b1;
      OP_BNE:   onehot[IDX_BNE]     = 1'b1;
      OP_SLTI:  onehot[IDX_SLTI]    = 1'b1;
      OP_SLTIU: onehot[IDX_SLTIU]   = 1'b1;
      OP_J:     onehot[IDX_J]       = 1'b1;
      OP_JAL:   onehot[IDX_JAL]     = 1'b1;
      default:  onehot[IDX_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered decode stage with two-entry skid buffer and stats
module instr_decode_stage
  import cpu31_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DEC_W-1:0] out_decoded,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] illegal_count
);

  logic [DEC_W-1:0] in_decoded;
  logic [DEC_W-1:0] skid_decoded;
  logic [31:0]      skid_instr;
  logic [PC_W-1:0]  skid_pc;
  buf_state_t       state;
  logic             in_hs;
  logic             out_hs;

  instr_onehot_decode u_decode (
    .instr  (in_instr),
    .onehot (in_decoded)
  );

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Occupancy FSM: output register first, skid slot absorbs one word under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BUF_EMPTY;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      out_decoded  <= '0;
      out_instr    <= '0;
      out_pc       <= '0;
      skid_decoded <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
    end else if (flush) begin
      state     <= BUF_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (in_hs) begin
            out_decoded <= in_decoded;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_valid   <= 1'b1;
            state       <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_hs && out_hs) begin
            out_decoded <= in_decoded;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
          end else if (in_hs) begin
            skid_decoded <= in_decoded;
            skid_instr   <= in_instr;
            skid_pc      <= in_pc;
            in_ready     <= 1'b0;
            state        <= BUF_TWO;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            state     <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so only the drain path can fire
          if (out_hs) begin
            out_decoded <= skid_decoded;
            out_instr   <= skid_instr;
            out_pc      <= skid_pc;
            in_ready    <= 1'b1;
            state       <= BUF_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= BUF_EMPTY;
        end
      endcase
    end
  end

  // Retirement statistics, counted on output handshakes and saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoded_count <= '0;
      illegal_count <= '0;
    end else if (out_hs) begin
      if (decoded_count != '1) begin
        decoded_count <= decoded_count + CNT_W'(1);
      end
      if (out_decoded[IDX_ILLEGAL] && (illegal_count != '1)) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end
  end

endmodule
